rgb_stream_gen: RTL and testbench
=================================

// Module: rgb_stream_gen
// PURPOSE
//  Frame-based RGB pixel stream transmitter. Drives the valid/r/g/b/width input side of imgpreProcess.
//  On a start pulse it emits img_height lines of img_width pixels, with a programmable blanking gap
//  between lines, using a selectable test pattern. Used as the on-chip source for preprocess bring-up.
// PARAMETERS
//  MAX_W    12'd2047  upper legal img_width; wider requests are clamped to MAX_W
//  MAX_H    12'd2047  upper legal img_height; taller requests are clamped to MAX_H
//  LFSR_SEED 24'hACE15A  LFSR load value at reset and at each accepted start
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse; begins a frame when idle
//  img_width  in   12  pixels per line; latched at start
//  img_height in   12  lines per frame; latched at start
//  hgap       in   8   idle cycles between lines; latched at start
//  pat_sel    in   2   0 solid, 1 ramp, 2 colour bars, 3 LFSR/checker; latched at start
//  solid_rgb  in   24  {R,G,B} colour for pat_sel=0; latched at start
//  dout_valid out  1   pixel qualifier (connects to imgpreProcess din_valid)
//  r_data     out  8   red
//  g_data     out  8   green
//  b_data     out  8   blue
//  width_out  out  12  latched line width (connects to imgpreProcess img_width)
//  sof        out  1   high with the first pixel of a frame
//  eol        out  1   high with the last pixel of every line
//  busy       out  1   high from the cycle after an accepted start until done
//  done       out  1   1-cycle pulse when the frame finishes
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM=IDLE, x/y counters 0, LFSR=LFSR_SEED.
//  - FSM IDLE->ACTIVE on start. ACTIVE->HGAP after the last pixel of a non-final line when hgap!=0.
//    ACTIVE->ACTIVE when hgap==0, so lines run back to back. HGAP->ACTIVE after exactly hgap idle cycles.
//    ACTIVE->FIN after the last pixel of the last line; no gap follows. FIN->IDLE with done=1 for one cycle.
//  - All outputs are registered. The first dout_valid appears in the cycle after start is sampled (latency 1).
//  - start while busy is ignored, and latched config does not change.
//  - start with img_width==0 or img_height==0: no pixels. busy stays 0; done pulses one cycle after start.
//  - Counters: x runs 0..W-1 and wraps to 0 at eol; y runs 0..H-1. Both are 12-bit with no overflow.
//  - Patterns, with x/y the pixel coordinates:
//    0: {r,g,b}=solid_rgb.
//    1: r=g=b=x[7:0], wrapping every 256 px.
//    2: bar=x[9:7], r={8{bar[2]}}, g={8{bar[1]}}, b={8{bar[0]}}.
//    3: see CONFIGURATION.
//  - r/g/b hold their last value while dout_valid=0. Consumers must qualify data with dout_valid.
//  - width_out holds the latched width, and keeps it after done until the next accepted start.
//  - Reset asserted mid-frame: immediate return to IDLE with outputs 0. No done pulse.
// CONFIGURATION
//  - RGB_GEN_LFSR_EN defined: pat_sel=3 uses a 24-bit Galois LFSR, taps x^24+x^23+x^22+x^17+1.
//    It reloads LFSR_SEED on accepted start and advances once per valid pixel. {r,g,b}=lfsr[23:0].
//  - RGB_GEN_LFSR_EN undefined: pat_sel=3 is a checker. r=g=b=(x[3]^y[3])?8'hFF:8'h00. No LFSR logic is built.
// TESTING
//  - Inputs W=4, H=2, hgap=3, pat=1, start. Required: valid runs 1111 000 1111; data 0,1,2,3 on each line;
//    sof on px0; eol on px3 and px7; done 1 cycle after the last pixel; 8 valids total.
//  - Inputs W=640, H=5, hgap=0, pat=2. Required: 3200 contiguous valids; bar colour changes at x=128,256,...;
//    width_out=640.
//  - pat=0 with solid_rgb=24'h123456, W=3, H=1. Required: three pixels r=12, g=34, b=56; done follows.
//  - W=0, H=7, start. Required: no dout_valid; busy stays 0; done pulse in the next cycle.
//  - Second start mid-frame with W=8. Required: it is ignored; frame finishes at the original W; width_out unchanged.
//  - rst_n low mid-line. Required: same-cycle outputs 0, no done. A new start gives px0 with sof.
//    With RGB_GEN_LFSR_EN, the first pixel is 24'hACE15A.

Source files
------------

// File: rtl/rgb_stream_if.sv
// RGB pixel stream bundle between rgb_stream_gen and its consumer.
// Carries pixel qualifier, colour, line width and frame/line markers.
interface rgb_stream_if;
  logic        dout_valid;
  logic [7:0]  r_data;
  logic [7:0]  g_data;
  logic [7:0]  b_data;
  logic [11:0] width_out;
  logic        sof;
  logic        eol;

  modport master (
    output dout_valid, r_data, g_data, b_data,
    output width_out, sof, eol
  );

  modport slave (
    input dout_valid, r_data, g_data, b_data,
    input width_out, sof, eol
  );
endinterface

// File: rtl/rgb_stream_gen.sv
// Frame-based RGB test-pattern stream source with line blanking.
// Define RGB_GEN_LFSR_EN to make pattern 3 a 24-bit Galois LFSR instead of a checker.
module rgb_stream_gen #(
  parameter logic [11:0] MAX_W     = 12'd2047,
  parameter logic [11:0] MAX_H     = 12'd2047,
  parameter logic [23:0] LFSR_SEED = 24'hACE15A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [11:0]  img_width,
  input  logic [11:0]  img_height,
  input  logic [7:0]   hgap,
  input  logic [1:0]   pat_sel,
  input  logic [23:0]  solid_rgb,
  rgb_stream_if.master stream,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HGAP, FIN} state_t;

  state_t      state;
  logic [11:0] w_q, h_q, x, y;
  logic [7:0]  gap_q, gcnt;
  logic [1:0]  pat_q;
  logic [23:0] solid_q;

  logic [11:0] w_in, h_in, nx, ny;
  logic        last_px, last_line, emit;
  logic [23:0] step_rgb, start_rgb;

`ifdef RGB_GEN_LFSR_EN
  logic [23:0] lfsr;

  function automatic logic [23:0] lfsr_next(input logic [23:0] l);
    return l[0] ? ((l >> 1) ^ 24'hE10000) : (l >> 1);
  endfunction
`endif

  function automatic logic [23:0] pix(
    input logic [1:0]  p,
    input logic [23:0] s,
    input logic [9:0]  xx,
    input logic        yb
  );
    logic [7:0] c;
    c = (xx[3] ^ yb) ? 8'hFF : 8'h00;
    unique case (p)
      2'd0:    return s;
      2'd1:    return {3{xx[7:0]}};
      2'd2:    return {{8{xx[9]}}, {8{xx[8]}}, {8{xx[7]}}};
      default: return {3{c}};
    endcase
  endfunction

  assign w_in = (img_width > MAX_W) ? MAX_W : img_width;
  assign h_in = (img_height > MAX_H) ? MAX_H : img_height;

  always_comb begin
    last_px   = (x == w_q - 12'd1);
    last_line = (y == h_q - 12'd1);
    nx        = last_px ? 12'd0 : x + 12'd1;
    ny        = last_px ? y + 12'd1 : y;
    emit      = 1'b0;
    unique case (state)
      ACTIVE:  emit = !(last_px && (last_line || gap_q != 8'd0));
      HGAP:    emit = (gcnt == gap_q);
      default: emit = 1'b0;
    endcase
    step_rgb  = pix(pat_q, solid_q, nx[9:0], ny[3]);
    start_rgb = pix(pat_sel, solid_rgb, 10'd0, 1'b0);
`ifdef RGB_GEN_LFSR_EN
    if (pat_q == 2'd3)   step_rgb  = lfsr;
    if (pat_sel == 2'd3) start_rgb = LFSR_SEED;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      w_q              <= '0;
      h_q              <= '0;
      x                <= '0;
      y                <= '0;
      gap_q            <= '0;
      gcnt             <= '0;
      pat_q            <= '0;
      solid_q          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.dout_valid <= 1'b0;
      stream.r_data    <= '0;
      stream.g_data    <= '0;
      stream.b_data    <= '0;
      stream.width_out <= '0;
      stream.sof       <= 1'b0;
      stream.eol       <= 1'b0;
`ifdef RGB_GEN_LFSR_EN
      lfsr             <= LFSR_SEED;
`endif
    end else begin
      done              <= 1'b0;
      stream.dout_valid <= 1'b0;
      stream.sof        <= 1'b0;
      stream.eol        <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          w_q              <= w_in;
          h_q              <= h_in;
          gap_q            <= hgap;
          pat_q            <= pat_sel;
          solid_q          <= solid_rgb;
          stream.width_out <= w_in;
          x                <= '0;
          y                <= '0;
          if (w_in == 12'd0 || h_in == 12'd0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state             <= ACTIVE;
            busy              <= 1'b1;
            stream.dout_valid <= 1'b1;
            stream.sof        <= 1'b1;
            stream.eol        <= (w_in == 12'd1);
            {stream.r_data, stream.g_data, stream.b_data} <= start_rgb;
`ifdef RGB_GEN_LFSR_EN
            lfsr <= lfsr_next(LFSR_SEED);
`endif
          end
        end
        ACTIVE: begin
          if (last_px && last_line) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (last_px && gap_q != 8'd0) begin
            state <= HGAP;
            gcnt  <= 8'd1;
          end
        end
        HGAP: begin
          if (gcnt == gap_q) state <= ACTIVE;
          else gcnt <= gcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
      // next pixel leaves in the same edge for back-to-back lines and gap exit
      if (emit) begin
        x                 <= nx;
        y                 <= ny;
        stream.dout_valid <= 1'b1;
        stream.eol        <= (nx == w_q - 12'd1);
        {stream.r_data, stream.g_data, stream.b_data} <= step_rgb;
`ifdef RGB_GEN_LFSR_EN
        lfsr <= lfsr_next(lfsr);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_gen.sv
// Self-checking bench for rgb_stream_gen against a cycle-trace reference model.
// Directed frames from the bring-up list plus randomized frames.
module tb_rgb_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] img_width = '0;
  logic [11:0] img_height = '0;
  logic [7:0]  hgap = '0;
  logic [1:0]  pat_sel = '0;
  logic [23:0] solid_rgb = '0;
  logic        busy, done;

  rgb_stream_if s();

  rgb_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_width(img_width), .img_height(img_height),
    .hgap(hgap), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
    .stream(s), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [23:0] rgb;
    logic        sof, eol, bsy, dn;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] last_rgb = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] step(input logic [23:0] l);
    return l[0] ? ((l >> 1) ^ 24'hE10000) : (l >> 1);
  endfunction

  function automatic logic [23:0] ref_pix(input int pat, input logic [23:0] sol,
                                          input int x, input int y,
                                          input logic [23:0] l);
    int bar;
    logic [7:0] c;
    bar = (x / 128) % 8;
    c = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
    case (pat)
      0: return sol;
      1: return {3{8'(x % 256)}};
      2: return {((bar / 4) % 2) ? 8'hFF : 8'h00,
                 ((bar / 2) % 2) ? 8'hFF : 8'h00,
                 (bar % 2) ? 8'hFF : 8'h00};
`ifdef RGB_GEN_LFSR_EN
      default: return l;
`else
      default: return {3{c}};
`endif
    endcase
  endfunction

  function automatic int clampv(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  task automatic build(input int w, input int h, input int gap,
                       input int pat, input logic [23:0] sol);
    logic [23:0] l;
    q.delete();
    l = 24'hACE15A;
    if (w != 0 && h != 0) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          last_rgb = ref_pix(pat, sol, x, y, l);
          q.push_back('{1'b1, last_rgb, (x == 0 && y == 0), (x == w - 1), 1'b1, 1'b0});
          l = step(l);
        end
        if (y < h - 1)
          for (int g = 0; g < gap; g++)
            q.push_back('{1'b0, last_rgb, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    q.push_back('{1'b0, last_rgb, 1'b0, 1'b0, 1'b0, 1'b1});
    q.push_back('{1'b0, last_rgb, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic run_frame(input int w, input int h, input int gap,
                           input int pat, input logic [23:0] sol,
                           input int restart_at, input int abort_at);
    int cw;
    cw = clampv(w);
    build(cw, clampv(h), gap, pat, sol);
    img_width = 12'(w);
    img_height = 12'(h);
    hgap = 8'(gap);
    pat_sel = 2'(pat);
    solid_rgb = sol;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    img_width = 12'($urandom);
    img_height = 12'($urandom);
    hgap = 8'($urandom);
    pat_sel = 2'($urandom);
    solid_rgb = 24'($urandom);
    foreach (q[i]) begin
      chk("valid", 32'(s.dout_valid), 32'(q[i].v));
      chk("rgb", 32'({s.r_data, s.g_data, s.b_data}), 32'(q[i].rgb));
      chk("sof", 32'(s.sof), 32'(q[i].sof));
      chk("eol", 32'(s.eol), 32'(q[i].eol));
      chk("busy", 32'(busy), 32'(q[i].bsy));
      chk("done", 32'(done), 32'(q[i].dn));
      chk("width", 32'(s.width_out), 32'(cw));
      if (i == abort_at) return;
      if (i == restart_at) begin
        start = 1'b1;
        img_width = 12'd8;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(s.dout_valid), 32'd0);
    chk({tag, "_rgb"}, 32'({s.r_data, s.g_data, s.b_data}), 32'd0);
    chk({tag, "_sof_eol"}, 32'({s.sof, s.eol}), 32'd0);
    chk({tag, "_width"}, 32'(s.width_out), 32'd0);
    chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    run_frame(4, 2, 3, 1, 24'h0, -1, -1);
    run_frame(640, 5, 0, 2, 24'h0, -1, -1);
    run_frame(3, 1, 2, 0, 24'h123456, -1, -1);
    run_frame(0, 7, 1, 1, 24'h0, -1, -1);
    run_frame(5, 0, 1, 1, 24'h0, -1, -1);
    run_frame(5, 3, 2, 1, 24'h0, 7, -1);
    run_frame(1, 3, 1, 2, 24'h0, -1, -1);
    run_frame(4000, 1, 0, 1, 24'h0, -1, -1);
    run_frame(20, 20, 1, 3, 24'h0, -1, -1);

    run_frame(10, 2, 2, 1, 24'h0, -1, 5);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_hold");
    rst_n = 1'b1;
    last_rgb = '0;
    @(negedge clk);
    chk_zero("after_reset");
    run_frame(6, 2, 1, 3, 24'h0, -1, -1);

    for (int k = 0; k < 12; k++)
      run_frame($urandom_range(1, 20), $urandom_range(1, 4),
                $urandom_range(0, 5), $urandom_range(0, 3),
                24'($urandom), -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
